riscv_mdu_ctrl: RTL and testbench
=================================

Name: riscv_mdu_ctrl

Overview:
- Sequencing controller for the shared multi-cycle multiply/divide datapath in the EX stage.
- Accepts an M-extension op from the ID/EX boundary and drives the datapath's start/step/last/abort strobes.
- Detects divide-by-zero and signed-overflow shortcuts, and produces the MDU contribution to the EX stall.
- Presents a result-valid/result-select pair to the EX result mux.

Parameters:
- XLEN, 32, operand width; also the divide iteration count.
- MUL_LATENCY, 3, multiply iteration cycles; legal range 1..XLEN.

Ports:
- rst_ni  in  1  asynchronous reset, active-low
- clk_i  in  1  clock
- req_i  in  1  valid MUL*/DIV*/REM* instruction presented by ID
- funct3_i  in  3  op select: [2]=0 multiply, 1 divide/remainder; for divides [0]=1 unsigned, [1]=1 remainder
- opA_i  in  XLEN  dividend / multiplicand, after bypass
- opB_i  in  XLEN  divisor / multiplier, after bypass
- ex_stall_i  in  1  stall from MEM and other EX units
- flush_i  in  1  pipeline flush (branch or state)
- mdu_stall_o  out  1  holds ID/EX while the MDU op is in flight
- dp_start_o  out  1  one-cycle pulse: datapath loads operands
- dp_op_o  out  3  registered funct3 of the op in flight
- dp_step_o  out  1  datapath performs one iteration this cycle
- dp_last_o  out  1  final iteration this cycle
- dp_abort_o  out  1  one-cycle pulse: datapath discards state
- res_valid_o  out  1  result available for the EX result mux
- res_sel_o  out  2  00 datapath, 01 all-ones, 10 captured opA, 11 zero

Behaviour:
- Reset: state IDLE, counter 0, dp_op_o 0. All outputs 0.
- States: IDLE, MUL, DIV, DONE. State, counter, dp_op_o and res_sel_o are registered.
- accept = req_i & ~ex_stall_i & ~flush_i & (state==IDLE). accept is never taken in DONE, because the completing instruction is still on req_i.
- On accept:
  - dp_start_o=1; capture funct3.
  - Multiply: go to MUL; counter = MUL_LATENCY-1.
  - Divide by zero (opB_i==0): go to DONE. res_sel = 01 for DIV/DIVU, 10 for REM/REMU.
  - Signed overflow (signed divide, opA_i==1<<(XLEN-1), opB_i=={XLEN{1}}): go to DONE. res_sel = 10 for DIV, 11 for REM.
  - Any other divide: go to DIV; counter = XLEN-1; res_sel = 00.
- MUL/DIV:
  - dp_step_o=1 every cycle; the counter decrements.
  - dp_last_o=1 when counter==0; the next state is DONE.
  - ex_stall_i does not pause iteration.
- DONE:
  - res_valid_o=1; mdu_stall_o=0.
  - Stay in DONE while ex_stall_i=1; go to IDLE the first cycle ex_stall_i=0.
- mdu_stall_o = accept | (state==MUL) | (state==DIV). It is combinational on req_i.
- Latency, with the accept cycle as T:
  - Multiply: DONE at T+MUL_LATENCY+1; stall high for T..T+MUL_LATENCY.
  - Normal divide: DONE at T+XLEN+1.
  - Shortcut divide: DONE at T+1; stall only at T.
- Back-to-back: DONE → IDLE, and the next op can be accepted in that IDLE cycle. Minimum 1 idle cycle between ops.
- flush_i:
  - From any state except IDLE: next state IDLE; dp_abort_o=1 in the flush cycle; res_valid_o is suppressed in that cycle.
  - In IDLE: no accept and no abort.
  - Takes priority over dp_last and DONE.
- Asynchronous reset mid-operation: immediate return to the reset values; no abort pulse.
- req_i deasserting mid-op (e.g. ID bubble after flush elsewhere) has no effect; only flush_i aborts.
- dp_op_o holds its value in DONE and IDLE until the next accept.

Test Plan:
- MULH request, opA=7, opB=6, MUL_LATENCY=3 → dp_start at T; dp_step T+1..T+3; dp_last at T+3; res_valid at T+4, res_sel=00; mdu_stall high T..T+3.
- DIVU opA=100, opB=7 → dp_step for 32 cycles; dp_last at T+32; res_valid at T+33, res_sel=00.
- DIV opB=0 → res_valid at T+1, res_sel=01, no dp_step. Then REMU opB=0 → res_sel=10. Then DIV 0x80000000/0xFFFFFFFF → res_sel=10. Then REM with the same operands → res_sel=11.
- ex_stall_i high from T+2 to T+40 during a DIV → iteration still ends at T+32. DONE holds res_valid until T+41, then IDLE. Also: ex_stall_i high in IDLE with req_i → no accept and no dp_start.
- flush_i at T+10 of a DIV → dp_abort pulse at T+10; IDLE at T+11; no res_valid. New MUL accepted at T+11.
- Two consecutive MULs → second dp_start exactly 1 cycle after the first DONE. Also: rst_ni low mid-DIV → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/riscv_mdu_ctrl.sv
// Sequencing controller for the shared multi-cycle multiply/divide datapath.
// Drives start/step/last/abort strobes, resolves divide shortcuts, and stalls EX.
module riscv_mdu_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic            rst_ni,
  input  logic            clk_i,
  input  logic            req_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] opA_i,
  input  logic [XLEN-1:0] opB_i,
  input  logic            ex_stall_i,
  input  logic            flush_i,
  output logic            mdu_stall_o,
  output logic            dp_start_o,
  output logic [2:0]      dp_op_o,
  output logic            dp_step_o,
  output logic            dp_last_o,
  output logic            dp_abort_o,
  output logic            res_valid_o,
  output logic [1:0]      res_sel_o
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] SEL_DP   = 2'b00;
  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_OPA  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      sel_q, sel_d;

  logic accept;
  logic is_div;
  logic div_zero;
  logic div_ovf;

  assign accept   = req_i & ~ex_stall_i & ~flush_i & (state_q == IDLE);
  assign is_div   = funct3_i[2];
  assign div_zero = (opB_i == '0);
  // Only signed divides (funct3[0]==0) can overflow: INT_MIN / -1.
  assign div_ovf  = ~funct3_i[0] & (opA_i == INT_MIN) & (opB_i == '1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sel_q   <= SEL_DP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sel_d       = sel_q;
    mdu_stall_o = 1'b0;
    dp_start_o  = 1'b0;
    dp_step_o   = 1'b0;
    dp_last_o   = 1'b0;
    dp_abort_o  = 1'b0;
    res_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mdu_stall_o = 1'b1;
          dp_start_o  = 1'b1;
          op_d        = funct3_i;
          if (!is_div) begin
            state_d = MUL;
            cnt_d   = CW'(MUL_LATENCY - 1);
            sel_d   = SEL_DP;
          end else if (div_zero) begin
            state_d = DONE;
            sel_d   = funct3_i[1] ? SEL_OPA : SEL_ONES;
          end else if (div_ovf) begin
            state_d = DONE;
            sel_d   = funct3_i[1] ? SEL_ZERO : SEL_OPA;
          end else begin
            state_d = DIV;
            cnt_d   = CW'(XLEN - 1);
            sel_d   = SEL_DP;
          end
        end
      end

      MUL, DIV: begin
        mdu_stall_o = 1'b1;
        // Flush wins over a final iteration; iteration ignores ex_stall_i.
        if (flush_i) begin
          dp_abort_o = 1'b1;
          state_d    = IDLE;
        end else begin
          dp_step_o = 1'b1;
          if (cnt_q == '0) begin
            dp_last_o = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      DONE: begin
        if (flush_i) begin
          dp_abort_o = 1'b1;
          state_d    = IDLE;
        end else begin
          res_valid_o = 1'b1;
          if (!ex_stall_i) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dp_op_o   = op_q;
  assign res_sel_o = sel_q;

endmodule

// File: tb/tb_riscv_mdu_ctrl.sv
// Directed-vector bench for riscv_mdu_ctrl: cycle-exact strobe, stall and
// result-select checks against hand-derived timelines.
module tb_riscv_mdu_ctrl;

  localparam int XLEN = 32;

  logic            rst_ni;
  logic            clk_i;
  logic            req_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] opA_i;
  logic [XLEN-1:0] opB_i;
  logic            ex_stall_i;
  logic            flush_i;
  logic            mdu_stall_o;
  logic            dp_start_o;
  logic [2:0]      dp_op_o;
  logic            dp_step_o;
  logic            dp_last_o;
  logic            dp_abort_o;
  logic            res_valid_o;
  logic [1:0]      res_sel_o;

  int n_vec = 0;
  int n_err = 0;

  riscv_mdu_ctrl #(.XLEN(XLEN), .MUL_LATENCY(3)) dut (
    .rst_ni      (rst_ni),
    .clk_i       (clk_i),
    .req_i       (req_i),
    .funct3_i    (funct3_i),
    .opA_i       (opA_i),
    .opB_i       (opB_i),
    .ex_stall_i  (ex_stall_i),
    .flush_i     (flush_i),
    .mdu_stall_o (mdu_stall_o),
    .dp_start_o  (dp_start_o),
    .dp_op_o     (dp_op_o),
    .dp_step_o   (dp_step_o),
    .dp_last_o   (dp_last_o),
    .dp_abort_o  (dp_abort_o),
    .res_valid_o (res_valid_o),
    .res_sel_o   (res_sel_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_cyc(input string tag, input bit st, input bit start, input bit stp,
                         input bit last, input bit abort, input bit valid);
    chk({tag, ".stall"}, 32'(mdu_stall_o), 32'(st));
    chk({tag, ".start"}, 32'(dp_start_o),  32'(start));
    chk({tag, ".step"},  32'(dp_step_o),   32'(stp));
    chk({tag, ".last"},  32'(dp_last_o),   32'(last));
    chk({tag, ".abort"}, 32'(dp_abort_o),  32'(abort));
    chk({tag, ".valid"}, 32'(res_valid_o), 32'(valid));
  endtask

  task automatic drive(input bit req, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit st, input bit fl);
    req_i      = req;
    funct3_i   = f3;
    opA_i      = a;
    opB_i      = b;
    ex_stall_i = st;
    flush_i    = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accept at T, n iterations T+1..T+n, DONE at T+n+1, optional idle cycle after.
  task automatic op_seq(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [1:0] sel,
                        input bit trail);
    drive(1, f3, a, b, 0, 0);
    @(negedge clk_i);
    exp_cyc({tag, ".acc"}, 1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_i);
      exp_cyc($sformatf("%s.it%0d", tag, i), 1, 0, 1, i == n, 0, 0);
      tick();
    end
    @(negedge clk_i);
    exp_cyc({tag, ".done"}, 0, 0, 0, 0, 0, 1);
    chk({tag, ".sel"}, 32'(res_sel_o), 32'(sel));
    chk({tag, ".op"},  32'(dp_op_o),   32'(f3));
    tick();
    if (trail) begin
      drive(0, 3'b000, 0, 0, 0, 0);
      @(negedge clk_i);
      exp_cyc({tag, ".idle"}, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 3'b000, 0, 0, 0, 0);
    #12;
    exp_cyc("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.op",  32'(dp_op_o),   32'd0);
    chk("rst.sel", 32'(res_sel_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Multiply and normal divides
    op_seq("mulh",  3'b001, 32'd7,        32'd6,        3,  2'b00, 1);
    op_seq("divu",  3'b101, 32'd100,      32'd7,        32, 2'b00, 1);
    // Unsigned INT_MIN / -1 is not an overflow shortcut
    op_seq("divu_m", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32, 2'b00, 1);

    // Shortcuts
    op_seq("div_z",  3'b100, 32'd55,       32'd0,        0, 2'b01, 1);
    op_seq("remu_z", 3'b111, 32'd55,       32'd0,        0, 2'b10, 1);
    op_seq("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 2'b10, 1);
    op_seq("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 2'b11, 1);

    // ex_stall_i high T+2..T+40 during DIV: iteration unaffected, DONE held to T+41
    drive(1, 3'b100, 32'd100, 32'd7, 0, 0);
    @(negedge clk_i);
    exp_cyc("stl.acc", 1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= 41; i++) begin
      ex_stall_i = (i >= 2 && i <= 40);
      @(negedge clk_i);
      if (i <= 32) exp_cyc($sformatf("stl.it%0d", i), 1, 0, 1, i == 32, 0, 0);
      else         exp_cyc($sformatf("stl.d%0d", i),  0, 0, 0, 0, 0, 1);
      tick();
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    @(negedge clk_i);
    exp_cyc("stl.idle", 0, 0, 0, 0, 0, 0);
    tick();

    // ex_stall_i in IDLE blocks accept
    drive(1, 3'b000, 32'd3, 32'd4, 1, 0);
    @(negedge clk_i);
    exp_cyc("idle_stl", 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    @(negedge clk_i);
    exp_cyc("idle_stl.nx", 0, 0, 0, 0, 0, 0);
    tick();

    // flush in IDLE: no accept, no abort
    drive(1, 3'b100, 32'd9, 32'd3, 0, 1);
    @(negedge clk_i);
    exp_cyc("idle_fl", 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    @(negedge clk_i);
    exp_cyc("idle_fl.nx", 0, 0, 0, 0, 0, 0);
    tick();

    // flush at T+10 of DIV, new MUL accepted at T+11
    drive(1, 3'b100, 32'd1000, 32'd3, 0, 0);
    @(negedge clk_i);
    exp_cyc("fl.acc", 1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      flush_i = (i == 10);
      @(negedge clk_i);
      if (i < 10) exp_cyc($sformatf("fl.it%0d", i), 1, 0, 1, 0, 0, 0);
      else        exp_cyc("fl.abort", 1, 0, 0, 0, 1, 0);
      tick();
    end
    op_seq("fl_mul", 3'b000, 32'd2, 32'd3, 3, 2'b00, 1);

    // flush in DONE suppresses res_valid
    drive(1, 3'b100, 32'd5, 32'd0, 0, 0);
    @(negedge clk_i);
    exp_cyc("fld.acc", 1, 1, 0, 0, 0, 0);
    tick();
    flush_i = 1'b1;
    @(negedge clk_i);
    exp_cyc("fld.done", 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    @(negedge clk_i);
    exp_cyc("fld.idle", 0, 0, 0, 0, 0, 0);
    tick();

    // Back-to-back multiplies: second accept one cycle after first DONE
    op_seq("b2b1", 3'b011, 32'd11, 32'd12, 3, 2'b00, 0);
    op_seq("b2b2", 3'b010, 32'd13, 32'd14, 3, 2'b00, 1);

    // Async reset mid-DIV
    drive(1, 3'b110, 32'd77, 32'd5, 0, 0);
    @(negedge clk_i);
    exp_cyc("ar.acc", 1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= 5; i++) tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #2;
    exp_cyc("ar.rst", 0, 0, 0, 0, 0, 0);
    chk("ar.op",  32'(dp_op_o),   32'd0);
    chk("ar.sel", 32'(res_sel_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    exp_cyc("ar.idle", 0, 0, 0, 0, 0, 0);
    tick();
    op_seq("ar.mul", 3'b000, 32'd1, 32'd1, 3, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
